// File: rtl/fetch_unit.sv
// fetch_unit: program-counter register and instruction-fetch sequencer for
// the 16-bit RISC core.
//
// It holds the architectural PC and keeps at most one request outstanding to
// instruction memory at a time. Each fetched word goes to decode through a
// valid/ready handshake. A redirect (pc_sel != 0) is taken in every state.
// If a redirect arrives while a fetch is still in flight, that fetch's data is
// thrown away when it returns.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   next_pc, pc_sel       next PC and select code from the next-PC selector
//   pc, pc_plus1          current PC (register) and combinational pc + 1
//   imem_req, imem_addr   fetch request and address (registers)
//   imem_ack, imem_data   memory response
//   ir, ir_pc, ir_valid   instruction register, its address, valid flag
//   ir_ready              decode accepts ir this cycle
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] next_pc,
  input  logic [1:0]  pc_sel,
  output logic [15:0] pc,
  output logic [15:0] pc_plus1,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic [15:0] ir,
  output logic [15:0] ir_pc,
  output logic        ir_valid,
  input  logic        ir_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] ir_pc_q, ir_pc_d;
  logic        ir_valid_q, ir_valid_d;
  logic        discard_q, discard_d;
  logic        redirect;

  assign redirect = (pc_sel != 2'b00);

  // Wraps modulo 2^16 because the result is truncated to 16 bits.
  assign pc_plus1 = pc_q + 16'd1;

  // NOTE: reset is applied to every register, including ir and ir_pc. These
  // are ordinary flops, not a memory array, so the reset costs nothing extra
  // and keeps the outputs deterministic from time zero.
  // NOTE: sequential state is written with non-blocking assignments. Every
  // register then samples its *_d value from before the edge, no matter what
  // order the statements are in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      ir_q       <= 16'h0000;
      ir_pc_q    <= 16'h0000;
      ir_valid_q <= 1'b0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      discard_q  <= discard_d;
    end
  end

  // NOTE: every variable starts from a default (hold its value) before the
  // case statement. No path can leave a variable unassigned, so no latch is
  // inferred.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_d      = req_q;
    addr_d     = addr_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    discard_d  = discard_q;

    // A redirect loads the PC in every state.
    if (redirect) begin
      pc_d = next_pc;
    end

    unique case (state_q)
      IDLE: begin
        if (!redirect) begin
          req_d   = 1'b1;
          addr_d  = pc_q;
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (imem_ack) begin
          req_d = 1'b0;
          if (redirect || discard_q) begin
            // This response belongs to a stale path, so drop it.
            discard_d = 1'b0;
            state_d   = IDLE;
          end else begin
            ir_d       = imem_data;
            ir_pc_d    = addr_q;
            ir_valid_d = 1'b1;
            pc_d       = next_pc;
            state_d    = HOLD;
          end
        end else if (redirect) begin
          // The request stays up until it is acked. Record that the data
          // coming back is no longer wanted.
          discard_d = 1'b1;
        end
      end

      HOLD: begin
        if (redirect) begin
          ir_valid_d = 1'b0;
          state_d    = IDLE;
        end else if (ir_ready) begin
          ir_valid_d = 1'b0;
          req_d      = 1'b1;
          addr_d     = pc_q;
          state_d    = WAIT;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign pc        = pc_q;
  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign ir        = ir_q;
  assign ir_pc     = ir_pc_q;
  assign ir_valid  = ir_valid_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Program-counter register and instruction-fetch sequencer for the 16-bit RISC core. It holds the architectural PC and drives `pc_plus1` into the next-PC selector. It consumes the selector's output (`next_pc`) and select code (`pc_sel`). It runs a single-outstanding req/ack handshake with instruction memory and presents one fetched instruction at a time to decode through a valid/ready handshake.

## Interface
- `RESET_PC`, default 16'h0000: PC value loaded on reset.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `next_pc`  in  16  next PC from the next-PC selector.
- `pc_sel`  in  2  selector control code.
  - 0 means sequential.
  - Any nonzero value means redirect (branch or jump).
- `pc`  out  16  current PC (register).
- `pc_plus1`  out  16  combinational `pc + 1`, modulo 2^16; feeds the selector's sequential input.
- `imem_req`  out  1  fetch request (register).
- `imem_addr`  out  16  fetch address (register), stable while `imem_req` = 1.
- `imem_ack`  in  1  memory has returned `imem_data` this cycle.
- `imem_data`  in  16  instruction word, valid when `imem_ack` = 1.
- `ir`  out  16  instruction register.
- `ir_pc`  out  16  address `ir` was fetched from.
- `ir_valid`  out  1  `ir` holds an instruction for decode.
- `ir_ready`  in  1  decode accepts `ir` this cycle.

## Operation
- Redirect is true in any cycle where `pc_sel` != 0.
- FSM states: IDLE, WAIT, HOLD.
- **IDLE**:
  - On redirect: `pc` <= `next_pc`; stay in IDLE.
  - Otherwise: `imem_req` <= 1, `imem_addr` <= `pc`; go to WAIT.
- **WAIT**:
  - `imem_req` stays 1 until `imem_ack`. A request is never withdrawn early.
  - On `imem_ack` with no redirect and `discard` = 0:
    - `ir` <= `imem_data`, `ir_pc` <= `imem_addr`, `ir_valid` <= 1.
    - `pc` <= `next_pc`.
    - `imem_req` <= 0; go to HOLD.
  - On redirect without ack: `pc` <= `next_pc`, `discard` <= 1; stay in WAIT.
  - On `imem_ack` with redirect or `discard` = 1:
    - Drop `imem_data`; `ir`/`ir_valid` are unchanged (invalid).
    - If redirect, `pc` <= `next_pc`.
    - `discard` <= 0, `imem_req` <= 0; go to IDLE.
- **HOLD** (`ir_valid` = 1):
  - On redirect (takes priority over `ir_ready`): `ir_valid` <= 0, `pc` <= `next_pc`; go to IDLE.
  - On `ir_ready`: `ir_valid` <= 0, `imem_req` <= 1, `imem_addr` <= `pc`; go to WAIT.
  - Otherwise hold all outputs.
- `ir` and `ir_pc` keep their last value when `ir_valid` = 0.
- Arithmetic: `pc_plus1` wraps, so 16'hFFFF maps to 16'h0000. No other arithmetic.
- `discard` is an internal 1-bit flag. It is only set in WAIT.

## Timing
- Reset (asynchronous, immediate):
  - `pc` = `RESET_PC`, `imem_addr` = `RESET_PC`.
  - `imem_req` = 0, `ir` = 0, `ir_pc` = 0, `ir_valid` = 0.
  - `discard` = 0, state = IDLE.
- First `imem_req` rises on the first clock edge after `rst_n` deasserts.
- Fetch latency: `ir_valid` rises on the edge after the cycle `imem_ack` is sampled.
- Best-case throughput, with `imem_ack` one cycle after req and `ir_ready` held at 1: one instruction per 2 cycles.
- Redirect is sampled each cycle. `pc` reflects `next_pc` the following cycle, in every state.
- Reset asserted mid-fetch abandons the transaction. Memory must tolerate `imem_req` dropping without ack under reset.

## Test plan
- **Reset and first fetch.** Hold `rst_n` = 0, then release; memory acks 1 cycle after req with 16'h1234.
  - During reset: all outputs at their reset values.
  - Next edge after release: `imem_req` = 1, `imem_addr` = 16'h0000.
  - Following cycle: `ir` = 16'h1234, `ir_pc` = 0, `ir_valid` = 1, `pc` = 1.
- **Sequential stream.** `pc_sel` = 0, `ir_ready` = 1, ack latency 1.
  - Fetch addresses are 0, 1, 2, 3, one per 2 cycles.
  - `ir_valid` pulses once per fetch.
- **Backpressure.** Hold `ir_ready` = 0 for 5 cycles in HOLD.
  - `ir`, `ir_valid` and `pc` are stable and `imem_req` = 0.
  - After `ir_ready` goes to 1, the next fetch is at `pc`.
- **Redirect during WAIT.** `pc_sel` = 1 with `next_pc` = 16'h0040 while the ack is delayed 3 cycles.
  - The returned word is dropped and `ir_valid` stays 0.
  - Next fetch address = 16'h0040.
- **Redirect and ready together in HOLD.** `pc_sel` = 2, `next_pc` = 16'h0100, `ir_ready` = 1.
  - `ir_valid` -> 0.
  - The state passes through IDLE, then fetches 16'h0100; `pc` = 16'h0100 stays stable while in IDLE.
- **Wrap-around.** `RESET_PC` = 16'hFFFF.
  - `pc_plus1` = 16'h0000.
  - After the first accepted fetch, `pc` = 0 and the next fetch address = 0.
